// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between requester A and B, round-robin on conflict.
// Define MEM_ARB_LOCK_EN to let a locking requester win conflicts for up to MAX_LOCK grants.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LOCK   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   input  logic                  a_lock,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   input  logic                  b_lock,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_dw,
   input  logic [DATA_WIDTH-1:0] mem_dr,
   output logic [15:0]           a_stall_cnt,
   output logic [15:0]           b_stall_cnt
);
   logic last_b, rd_vld, rd_tag, pick_b;
`ifdef MEM_ARB_LOCK_EN
   localparam int LW = $clog2(MAX_LOCK + 1);
   localparam logic [LW-1:0] LMAX = LW'(MAX_LOCK);
   logic own_vld, own_b, own_live;
   logic [LW-1:0] lock_cnt;
   // A live owner keeps winning conflicts until it has used MAX_LOCK grants in a row
   assign own_live = own_vld & (own_b ? b_req & b_lock : a_req & a_lock);
   assign pick_b = (own_live & (lock_cnt != LMAX)) ? own_b : ~last_b;
   always_ff @(posedge clk)
      if (reset) begin
         own_vld  <= 1'b0;
         own_b    <= 1'b0;
         lock_cnt <= '0;
      end else if (a_gnt & a_lock) begin
         own_vld  <= 1'b1;
         own_b    <= 1'b0;
         lock_cnt <= (own_live & ~own_b) ? lock_cnt + LW'(lock_cnt != LMAX) : LW'(1);
      end else if (b_gnt & b_lock) begin
         own_vld  <= 1'b1;
         own_b    <= 1'b1;
         lock_cnt <= (own_live & own_b) ? lock_cnt + LW'(lock_cnt != LMAX) : LW'(1);
      end else
         own_vld  <= 1'b0;
`else
   logic unused_lock;
   assign unused_lock = a_lock ^ b_lock ^ (MAX_LOCK == 0);
   assign pick_b = ~last_b;
`endif
   assign a_gnt    = ~reset & a_req & (~b_req | ~pick_b);
   assign b_gnt    = ~reset & b_req & (~a_req | pick_b);
   assign mem_en   = a_gnt | b_gnt;
   assign mem_we   = b_gnt ? b_we : a_gnt & a_we;
   assign mem_addr = b_gnt ? b_addr : a_addr;
   assign mem_dw   = b_gnt ? b_wdata : a_wdata;
   // rd_tag names the requester that owns the read returning this cycle
   assign a_rvalid = rd_vld & ~rd_tag;
   assign b_rvalid = rd_vld & rd_tag;
   assign a_rdata  = a_rvalid ? mem_dr : '0;
   assign b_rdata  = b_rvalid ? mem_dr : '0;
   always_ff @(posedge clk)
      if (reset) begin
         last_b      <= 1'b1;
         rd_vld      <= 1'b0;
         rd_tag      <= 1'b0;
         a_stall_cnt <= '0;
         b_stall_cnt <= '0;
      end else begin
         if (mem_en) last_b <= b_gnt;
         rd_vld <= mem_en & ~mem_we;
         rd_tag <= b_gnt;
         if (a_req & ~a_gnt & ~&a_stall_cnt) a_stall_cnt <= a_stall_cnt + 16'd1;
         if (b_req & ~b_gnt & ~&b_stall_cnt) b_stall_cnt <= b_stall_cnt + 16'd1;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, read routing, stall counters and reset.
module tb_mem_port_arbiter;
   logic clk = 1'b0, reset = 1'b1;
   logic a_req = 0, a_we = 0, a_lock = 0, b_req = 0, b_we = 0, b_lock = 0;
   logic [15:0] a_addr = '0, b_addr = '0, mem_addr;
   logic [31:0] a_wdata = '0, b_wdata = '0, mem_dw, mem_dr = '0, a_rdata, b_rdata;
   logic a_gnt, a_rvalid, b_gnt, b_rvalid, mem_en, mem_we;
   logic [15:0] a_stall_cnt, b_stall_cnt;
   logic wr_ok = 1'b0;
   logic [15:0] wr_a = '0;
   logic [31:0] wr_d = '0;
   int checks = 0, errors = 0;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dw(mem_dw), .mem_dr(mem_dr),
      .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [15:0] a);
      return (a == 16'h0010) ? 32'hDEADBEEF : {16'hA000, a};
   endfunction

   // image memory: one-cycle read latency, remembers the most recent write
   always @(posedge clk) begin
      if (reset) wr_ok <= 1'b0;
      else if (mem_en & mem_we) begin
         wr_ok <= 1'b1;
         wr_a  <= mem_addr;
         wr_d  <= mem_dw;
      end
      if (mem_en & ~mem_we) mem_dr <= (wr_ok && wr_a == mem_addr) ? wr_d : word_at(mem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset blocks grants; then A reads 0x0010 alone
      a_req = 1; a_addr = 16'h0010;
      #1;
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      tick;
      chk("rst_a_stall", a_stall_cnt, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      reset = 0;
      #1;
      chk("t1_a_gnt", a_gnt, 1);
      chk("t1_mem_en", mem_en, 1);
      chk("t1_mem_we", mem_we, 0);
      chk("t1_mem_addr", mem_addr, 32'h10);
      tick;
      a_req = 0;
      chk("t1_a_rvalid", a_rvalid, 1);
      chk("t1_a_rdata", a_rdata, 32'hDEADBEEF);
      chk("t1_b_rvalid", b_rvalid, 0);
      chk("t1_b_rdata", b_rdata, 0);
      #1;
      chk("t1_idle_en", mem_en, 0);
      tick;
      chk("t1_idle_rvalid", a_rvalid, 0);

      // both reading from the first cycle after reset: A,B,A,B
      reset = 1;
      tick;
      reset = 0; a_req = 1; b_req = 1; a_addr = 16'h0020; b_addr = 16'h0030;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_a_gnt", a_gnt, i % 2 == 0);
         chk("rr_b_gnt", b_gnt, i % 2 == 1);
         chk("rr_addr", mem_addr, (i % 2 == 0) ? 32'h20 : 32'h30);
         tick;
         chk("rr_a_rvalid", a_rvalid, i % 2 == 0);
         chk("rr_b_rvalid", b_rvalid, i % 2 == 1);
         chk("rr_a_rdata", a_rdata, (i % 2 == 0) ? 32'hA0000020 : 32'h0);
         chk("rr_b_rdata", b_rdata, (i % 2 == 1) ? 32'hA0000030 : 32'h0);
         chk("rr_a_stall", a_stall_cnt, (i + 1) / 2);
         chk("rr_b_stall", b_stall_cnt, i / 2 + 1);
      end

      // A holds a_lock while both request continuously
      reset = 1; a_req = 0; b_req = 0;
      tick;
      reset = 0; a_lock = 1; a_req = 1; b_req = 1;
      for (int i = 0; i < 18; i++) begin
         logic exp_b;
`ifdef MEM_ARB_LOCK_EN
         exp_b = (i % 9 == 8);
`else
         exp_b = (i % 2 == 1);
`endif
         #1;
         chk("lk_a_gnt", a_gnt, !exp_b);
         chk("lk_b_gnt", b_gnt, exp_b);
         tick;
      end
      a_lock = 0;

      // B alone writes 0x12345678 to 0x00FF four times
      a_req = 0; b_req = 1; b_we = 1; b_addr = 16'h00FF; b_wdata = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("wr_b_gnt", b_gnt, 1);
         chk("wr_mem_we", mem_we, 1);
         chk("wr_mem_addr", mem_addr, 32'hFF);
         chk("wr_mem_dw", mem_dw, 32'h12345678);
         tick;
         chk("wr_a_rvalid", a_rvalid, 0);
         chk("wr_b_rvalid", b_rvalid, 0);
         chk("wr_a_rdata", a_rdata, 0);
      end
      b_req = 0; b_we = 0; a_req = 1; a_addr = 16'h00FF;
      #1;
      chk("rb_a_gnt", a_gnt, 1);
      tick;
      a_req = 0;
      chk("rb_a_rvalid", a_rvalid, 1);
      chk("rb_a_rdata", a_rdata, 32'h12345678);

      // A granted last, then reset lands on a cycle with A requesting
      a_req = 1; a_addr = 16'h0020;
      #1;
      chk("pre_a_gnt", a_gnt, 1);
      tick;
      reset = 1; b_req = 1; b_addr = 16'h0030;
      #1;
      chk("mr_a_gnt", a_gnt, 0);
      chk("mr_b_gnt", b_gnt, 0);
      chk("mr_mem_en", mem_en, 0);
      tick;
      chk("mr_a_rvalid", a_rvalid, 0);
      chk("mr_b_rvalid", b_rvalid, 0);
      chk("mr_a_stall", a_stall_cnt, 0);
      chk("mr_b_stall", b_stall_cnt, 0);
      reset = 0;
      #1;
      chk("mr_first_a", a_gnt, 1);
      chk("mr_first_b", b_gnt, 0);

      // stall counters preloaded near the top, then run into saturation
      force dut.a_stall_cnt = 16'hFFFD;
      force dut.b_stall_cnt = 16'hFFFD;
      #1;
      release dut.a_stall_cnt;
      release dut.b_stall_cnt;
      repeat (3) tick;
      chk("sat_b_top", b_stall_cnt, 32'hFFFF);
      chk("sat_a_mid", a_stall_cnt, 32'hFFFE);
      repeat (3) tick;
      chk("sat_a_hold", a_stall_cnt, 32'hFFFF);
      chk("sat_b_hold", b_stall_cnt, 32'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
